// File: rtl/float_to_fixed_pkg.sv
// Shared types for the float-to-fixed converter.
// Provides the IEEE-754 single field layout, exponent bias, the input class
// enum and a classifier used by the unpack stage.
package float_to_fixed_pkg;

  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } ieee_single_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Denormals fall into CLS_ZERO: they are flushed to an exact zero.
  function automatic cls_e classify(input ieee_single_t f);
    if (f.exp == 8'h00)      return CLS_ZERO;
    else if (f.exp != 8'hFF) return CLS_NORM;
    else if (f.mant == '0)   return CLS_INF;
    else                     return CLS_NAN;
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Final stage logic of float_to_fixed_pipe: optional rounding, saturation
// and negation of the aligned magnitude (purely combinational; the caller
// registers the outputs).
// Ports:
//   i_sign  : sign of the input value
//   i_sat   : force saturation (Inf or exponent far above range)
//   i_nan   : input was NaN
//   i_guard : first bit below the LSB (only with FLOAT_TO_FIXED_ROUND_EN)
//   i_mag   : aligned magnitude, one bit wider than INTS+FRACS
//   o_fixed : fixed-point result, o_ovf : saturated, o_nan : NaN flag
module fx_round_sat
  import float_to_fixed_pkg::*;
#(
  parameter int INTS   = 1,
  parameter int FRACS  = 22,
  parameter int SIGNED = 0,
  parameter int WIDTH  = SIGNED + INTS + FRACS
) (
  input  logic                   i_sign,
  input  logic                   i_sat,
  input  logic                   i_nan,
`ifdef FLOAT_TO_FIXED_ROUND_EN
  input  logic                   i_guard,
`endif
  input  logic [INTS+FRACS:0]    i_mag,
  output logic [WIDTH-1:0]       o_fixed,
  output logic                   o_ovf,
  output logic                   o_nan
);

  localparam int MAGW = INTS + FRACS;
  localparam logic [MAGW+1:0]  LIM  = {2'b01, {MAGW{1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [MAGW+1:0] w_rnd;
  logic [MAGW+1:0] w_neg;

  // Ties-away-from-zero on the magnitude only needs the guard bit: any
  // remainder of half an LSB or more rounds up, regardless of sticky bits.
`ifdef FLOAT_TO_FIXED_ROUND_EN
  assign w_rnd = {1'b0, i_mag} + {{(MAGW+1){1'b0}}, i_guard};
`else
  assign w_rnd = {1'b0, i_mag};
`endif
  assign w_neg = '0 - w_rnd;

  always_comb begin
    o_fixed = '0;
    o_ovf   = 1'b0;
    o_nan   = 1'b0;
    if (i_nan) begin
      o_nan = 1'b1;
    end else if (SIGNED == 0) begin
      if (i_sat || w_rnd >= LIM) begin
        o_fixed = '1;
        o_ovf   = 1'b1;
      end else begin
        o_fixed = WIDTH'(w_rnd);
      end
    end else if (i_sign) begin
      // Magnitude exactly 2^MAGW is -2^INTS, still representable.
      if (i_sat || w_rnd > LIM) begin
        o_fixed = SMIN;
        o_ovf   = 1'b1;
      end else begin
        o_fixed = WIDTH'(w_neg);
      end
    end else begin
      if (i_sat || w_rnd >= LIM) begin
        o_fixed = SMAX;
        o_ovf   = 1'b1;
      end else begin
        o_fixed = WIDTH'(w_rnd);
      end
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// IEEE-754 single to fixed-point converter, 3-stage valid/ready pipeline:
// S1 unpack/classify, S2 align shift, S3 round/saturate/negate.
// Optional macro FLOAT_TO_FIXED_ROUND_EN selects round-to-nearest
// (ties away from zero); otherwise the magnitude is truncated.
// Ports:
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake, in_float = IEEE single word
//   out_valid/out_ready    : output handshake
//   out_fixed              : result (WIDTH bits), out_ovf saturated, out_nan NaN
module float_to_fixed_pipe
  import float_to_fixed_pkg::*;
#(
  parameter int INTS   = 1,
  parameter int FRACS  = 22,
  parameter int SIGNED = 0,
  parameter int WIDTH  = SIGNED + INTS + FRACS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_fixed,
  output logic             out_ovf,
  output logic             out_nan
);

  localparam int MAGW = INTS + FRACS;
  localparam int MW1  = MAGW + 1;
  // Result = sig24 * 2^(exp - EXP_BIAS + FRACS - 23).
  localparam logic signed [10:0] SH_OFS = 11'(FRACS - EXP_BIAS - 23);
  // From this shift on, the leading one lands at or above bit MW1.
  localparam logic signed [10:0] OVF_SH = 11'(MAGW - 22);

  logic         w_stall;
  ieee_single_t w_in;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_in     = in_float;

  // ---------------- S1: unpack / classify ----------------
  logic        r1_valid, r1_sign;
  cls_e        r1_cls;
  logic [7:0]  r1_exp;
  logic [23:0] r1_sig;

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_cls   <= CLS_ZERO;
      r1_exp   <= '0;
      r1_sig   <= '0;
    end else if (!w_stall) begin
      r1_valid <= in_valid;
      r1_sign  <= w_in.sign;
      r1_cls   <= classify(w_in);
      r1_exp   <= w_in.exp;
      r1_sig   <= {1'b1, w_in.mant};
    end
  end

  // ---------------- S2: align shift ----------------
  logic signed [10:0] w_sh;
  logic [10:0]        w_rsh_full;
  logic [4:0]         w_rsh;
  logic               w_big;
  logic [MW1-1:0]     w_mag;
`ifdef FLOAT_TO_FIXED_ROUND_EN
  logic [24:0]        w_gx;
  logic               w_guard;
`endif

  // Right shifts are clamped just past the significand width so that a
  // huge negative exponent cannot wrap the shifter into a nonzero result.
  always_comb begin
    w_sh       = $signed({3'b000, r1_exp}) + SH_OFS;
    w_big      = (w_sh >= OVF_SH);
    w_rsh_full = 11'(-w_sh);
    w_mag      = '0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    w_rsh   = (w_rsh_full > 11'd25) ? 5'd25 : w_rsh_full[4:0];
    w_gx    = {r1_sig, 1'b0} >> w_rsh;
    w_guard = 1'b0;
`else
    w_rsh   = (w_rsh_full > 11'd24) ? 5'd24 : w_rsh_full[4:0];
`endif
    if (!w_sh[10]) begin
      // Non-overflowing left shifts are at most 9, so 4 bits suffice.
      w_mag = MW1'(r1_sig) << w_sh[3:0];
    end else begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
      w_mag   = MW1'(w_gx[24:1]);
      w_guard = w_gx[0];
`else
      w_mag   = MW1'(r1_sig >> w_rsh);
`endif
    end
  end

  logic           r2_valid, r2_sign, r2_sat, r2_nan;
  logic [MW1-1:0] r2_mag;
`ifdef FLOAT_TO_FIXED_ROUND_EN
  logic           r2_guard;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_sat   <= 1'b0;
      r2_nan   <= 1'b0;
      r2_mag   <= '0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
      r2_guard <= 1'b0;
`endif
    end else if (!w_stall) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_sat   <= (r1_cls == CLS_INF) || (r1_cls == CLS_NORM && w_big);
      r2_nan   <= (r1_cls == CLS_NAN);
      r2_mag   <= (r1_cls == CLS_NORM && !w_big) ? w_mag : '0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
      r2_guard <= (r1_cls == CLS_NORM && !w_big) ? w_guard : 1'b0;
`endif
    end
  end

  // ---------------- S3: round / saturate / negate ----------------
  logic [WIDTH-1:0] w_fixed;
  logic             w_ovf, w_nan;

  fx_round_sat #(
    .INTS   (INTS),
    .FRACS  (FRACS),
    .SIGNED (SIGNED)
  ) u_round_sat (
    .i_sign  (r2_sign),
    .i_sat   (r2_sat),
    .i_nan   (r2_nan),
`ifdef FLOAT_TO_FIXED_ROUND_EN
    .i_guard (r2_guard),
`endif
    .i_mag   (r2_mag),
    .o_fixed (w_fixed),
    .o_ovf   (w_ovf),
    .o_nan   (w_nan)
  );

  logic             r3_valid, r3_ovf, r3_nan;
  logic [WIDTH-1:0] r3_fixed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r3_valid <= 1'b0;
      r3_fixed <= '0;
      r3_ovf   <= 1'b0;
      r3_nan   <= 1'b0;
    end else if (!w_stall) begin
      r3_valid <= r2_valid;
      r3_fixed <= w_fixed;
      r3_ovf   <= w_ovf;
      r3_nan   <= w_nan;
    end
  end

  assign out_valid = r3_valid;
  assign out_fixed = r3_fixed;
  assign out_ovf   = r3_ovf;
  assign out_nan   = r3_nan;

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed bench for float_to_fixed_pipe: one instance with defaults
// (unsigned, 1.22) and one with SIGNED=1 (s1.22), sharing all inputs.
module tb_float_to_fixed_pipe;

  localparam bit RND =
`ifdef FLOAT_TO_FIXED_ROUND_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [31:0] f;
    logic [23:0] fx;
    logic        ovf;
    logic        nan;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_float = '0;
  logic        out_ready = 1'b1;

  logic        u_in_ready, u_out_valid, u_out_ovf, u_out_nan;
  logic [22:0] u_out_fixed;
  logic        s_in_ready, s_out_valid, s_out_ovf, s_out_nan;
  logic [23:0] s_out_fixed;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  float_to_fixed_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_float(in_float), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_fixed(u_out_fixed), .out_ovf(u_out_ovf), .out_nan(u_out_nan)
  );

  float_to_fixed_pipe #(.SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_float(in_float), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_fixed(s_out_fixed), .out_ovf(s_out_ovf), .out_nan(s_out_nan)
  );

  // Offers one word on an idle pipeline and captures both results; lat is
  // the number of falling edges after the accepting edge (0 = timed out).
  task automatic xfer(input logic [31:0] f,
                      output logic [22:0] ufx, output logic uovf, output logic unan,
                      output logic [23:0] sfx, output logic sovf, output logic snan,
                      output int lat);
    @(negedge clk);
    in_float = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; ufx = '0; uovf = 1'b0; unan = 1'b0; sfx = '0; sovf = 1'b0; snan = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (u_out_valid) begin
        lat = c;
        ufx = u_out_fixed; uovf = u_out_ovf; unan = u_out_nan;
        sfx = s_out_fixed; sovf = s_out_ovf; snan = s_out_nan;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (u_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b/%b want 0/0", u_out_valid, s_out_valid);
    end
    vectors++;
    if (u_out_fixed !== 23'h0 || s_out_fixed !== 24'h0) begin
      miscompares++; $display("FAIL reset_fixed: got %h/%h want 0", u_out_fixed, s_out_fixed);
    end
    vectors++;
    if ({u_out_ovf, u_out_nan, s_out_ovf, s_out_nan} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {u_out_ovf, u_out_nan, s_out_ovf, s_out_nan});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b/%b want 1/1", u_in_ready, s_in_ready);
    end
  endtask

  task automatic test_unsigned();
    vec_t v[13];
    logic [22:0] ufx; logic uovf, unan; logic [23:0] sfx; logic sovf, snan; int lat;
    v = '{
      '{32'h3F800000, 24'h400000, 1'b0, 1'b0},
      '{32'h3F000000, 24'h200000, 1'b0, 1'b0},
      '{32'h40000000, 24'h7FFFFF, 1'b1, 1'b0},
      '{32'hBF800000, 24'h400000, 1'b0, 1'b0},
      '{32'h7FC00000, 24'h000000, 1'b0, 1'b1},
      '{32'h7F800000, 24'h7FFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 24'h7FFFFF, 1'b1, 1'b0},
      '{32'h34000000, (RND ? 24'h000001 : 24'h000000), 1'b0, 1'b0},
      '{32'h34400000, (RND ? 24'h000001 : 24'h000000), 1'b0, 1'b0},
      '{32'h33800000, 24'h000000, 1'b0, 1'b0},
      '{32'h00000001, 24'h000000, 1'b0, 1'b0},
      '{32'h3FFFFFFF, 24'h7FFFFF, RND, 1'b0},
      '{32'h3F800001, (RND ? 24'h400001 : 24'h400000), 1'b0, 1'b0}
    };
    for (int i = 0; i < 13; i++) begin
      xfer(v[i].f, ufx, uovf, unan, sfx, sovf, snan, lat);
      vectors++;
      if (lat !== 3) begin
        miscompares++; $display("FAIL u_latency[%h]: got %0d want 3", v[i].f, lat);
      end
      vectors++;
      if ({1'b0, ufx} !== v[i].fx) begin
        miscompares++; $display("FAIL u_fixed[%h]: got %h want %h", v[i].f, ufx, v[i].fx);
      end
      vectors++;
      if (uovf !== v[i].ovf || unan !== v[i].nan) begin
        miscompares++; $display("FAIL u_flags[%h]: got ovf=%b nan=%b want ovf=%b nan=%b",
                                v[i].f, uovf, unan, v[i].ovf, v[i].nan);
      end
    end
  endtask

  task automatic test_signed();
    vec_t v[11];
    logic [22:0] ufx; logic uovf, unan; logic [23:0] sfx; logic sovf, snan; int lat;
    v = '{
      '{32'hBF800000, 24'hC00000, 1'b0, 1'b0},
      '{32'hC0000000, 24'h800000, 1'b0, 1'b0},
      '{32'hFF800000, 24'h800000, 1'b1, 1'b0},
      '{32'h7F800000, 24'h7FFFFF, 1'b1, 1'b0},
      '{32'h40000000, 24'h7FFFFF, 1'b1, 1'b0},
      '{32'hC0000001, 24'h800000, 1'b1, 1'b0},
      '{32'h3F800000, 24'h400000, 1'b0, 1'b0},
      '{32'h80000000, 24'h000000, 1'b0, 1'b0},
      '{32'h7FC00000, 24'h000000, 1'b0, 1'b1},
      '{32'hB4000000, (RND ? 24'hFFFFFF : 24'h000000), 1'b0, 1'b0},
      '{32'hBFFFFFFF, (RND ? 24'h800000 : 24'h800001), 1'b0, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      xfer(v[i].f, ufx, uovf, unan, sfx, sovf, snan, lat);
      vectors++;
      if (lat !== 3) begin
        miscompares++; $display("FAIL s_latency[%h]: got %0d want 3", v[i].f, lat);
      end
      vectors++;
      if (sfx !== v[i].fx) begin
        miscompares++; $display("FAIL s_fixed[%h]: got %h want %h", v[i].f, sfx, v[i].fx);
      end
      vectors++;
      if (sovf !== v[i].ovf || snan !== v[i].nan) begin
        miscompares++; $display("FAIL s_flags[%h]: got ovf=%b nan=%b want ovf=%b nan=%b",
                                v[i].f, sovf, snan, v[i].ovf, v[i].nan);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] w[8];
    logic [22:0] e[8];
    int sent, rcv, stalls;
    logic fire_in, fire_out;
    w = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3F400000,
          32'h3FC00000, 32'h3E000000, 32'h3FE00000, 32'h3EC00000};
    e = '{23'h400000, 23'h200000, 23'h100000, 23'h300000,
          23'h600000, 23'h080000, 23'h700000, 23'h180000};
    sent = 0; rcv = 0; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_float = w[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (u_out_valid && !out_ready) begin
        stalls++;
        vectors++;
        if (u_in_ready !== 1'b0) begin
          miscompares++; $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, u_in_ready);
        end
        vectors++;
        if (rcv >= 8 || u_out_fixed !== e[rcv]) begin
          miscompares++; $display("FAIL stall_hold[c%0d]: got %h want item %0d", c, u_out_fixed, rcv);
        end
      end
      fire_in  = in_valid & u_in_ready;
      fire_out = u_out_valid & out_ready;
      if (fire_out) begin
        vectors++;
        if (rcv >= 8) begin
          miscompares++; $display("FAIL stream_extra: got %h want none", u_out_fixed);
        end else if (u_out_fixed !== e[rcv]) begin
          miscompares++; $display("FAIL stream_item%0d: got %h want %h", rcv, u_out_fixed, e[rcv]);
        end
        rcv++;
      end
      @(posedge clk);
      if (fire_in) sent++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (rcv !== 8) begin
      miscompares++; $display("FAIL stream_count: got %0d want 8", rcv);
    end
    vectors++;
    if (stalls !== 5) begin
      miscompares++; $display("FAIL stream_stall_cycles: got %0d want 5", stalls);
    end
    vectors++;
    if (sent !== 8) begin
      miscompares++; $display("FAIL stream_sent: got %0d want 8", sent);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] w[3];
    int seen;
    logic [22:0] ufx; logic uovf, unan; logic [23:0] sfx; logic sovf, snan; int lat;
    w = '{32'h40000000, 32'h7FC00000, 32'h3F800000};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_float = w[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (u_out_valid !== 1'b1) begin
      miscompares++; $display("FAIL flush_setup_valid: got %b want 1", u_out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (u_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_valid: got %b/%b want 0/0", u_out_valid, s_out_valid);
    end
    vectors++;
    if (u_out_fixed !== 23'h0 || u_out_ovf !== 1'b0 || u_out_nan !== 1'b0) begin
      miscompares++; $display("FAIL flush_outputs: got %h ovf=%b nan=%b want 0", u_out_fixed, u_out_ovf, u_out_nan);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (u_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_in_ready: got %b want 1", u_in_ready);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (u_out_valid || s_out_valid) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL flush_ghosts: got %0d want 0", seen);
    end
    xfer(32'h3F000000, ufx, uovf, unan, sfx, sovf, snan, lat);
    vectors++;
    if (lat !== 3 || ufx !== 23'h200000) begin
      miscompares++; $display("FAIL flush_recover: got lat=%0d fx=%h want lat=3 fx=200000", lat, ufx);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back_stall();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
